// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
// Holds the FSM state enum, the grant-index width calculation and one-hot decode.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic int idw_calc(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int onehot2bin(input logic [31:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_v searching from last+1,
// wrapping modulo N.
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req_v,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   pick_oh,
    output logic           any
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        pick_oh = '0;
        found   = 1'b0;
        idx     = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IDW'((int'(last) + off) % N);
            if (!found && req_v[idx]) begin
                pick_oh[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign any = |req_v;

endmodule

// File: rtl/arb_rr_sched.sv
// Registered round-robin scheduler sharing one slave port between N masters,
// with optional MAX_HOLD timeout preemption that lock can inhibit.
module arb_rr_sched
    import arb_pkg::*;
#(
    parameter int  N        = 2,
    parameter int  MAX_HOLD = 16,
    localparam int IDW      = idw_calc(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           preempt
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // With MAX_HOLD=0 the counter only serves as a saturating flag; it never preempts.
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? HW'(1) : HW'(MAX_HOLD - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] last_q, last_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           busy_q, busy_d;
    logic           preempt_q, preempt_d;

    logic [N-1:0]   pick_req, pick_oth, new_gnt;
    logic           any_req, any_oth, take, cur_req, cur_lock;

    rr_pick #(.N(N), .IDW(IDW)) u_pick_req (
        .req_v   (req),
        .last    (last_q),
        .pick_oh (pick_req),
        .any     (any_req)
    );

    rr_pick #(.N(N), .IDW(IDW)) u_pick_oth (
        .req_v   (req & ~gnt_q),
        .last    (last_q),
        .pick_oh (pick_oth),
        .any     (any_oth)
    );

    assign cur_req  = |(req & gnt_q);
    assign cur_lock = |(lock & gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        new_gnt   = '0;
        take      = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        take    = 1'b1;
                        new_gnt = pick_req;
                    end
                end
                GRANT: begin
                    if (!cur_req) begin
                        if (any_oth) begin
                            take    = 1'b1;
                            new_gnt = pick_oth;
                        end else begin
                            state_d  = IDLE;
                            gnt_d    = '0;
                            gnt_id_d = '0;
                            busy_d   = 1'b0;
                            hold_d   = '0;
                        end
                    end else if (MAX_HOLD != 0 && hold_q == HOLD_SAT && !cur_lock && any_oth) begin
                        take      = 1'b1;
                        new_gnt   = pick_oth;
                        preempt_d = 1'b1;
                    end else if (hold_q != HOLD_SAT) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                default: ;
            endcase
            // last always tracks the current owner, so both pickers search from it.
            if (take) begin
                state_d  = GRANT;
                gnt_d    = new_gnt;
                gnt_id_d = IDW'(onehot2bin(32'(new_gnt)));
                last_d   = gnt_id_d;
                hold_d   = '0;
                busy_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_q    <= IDW'(N - 1);
            hold_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

    a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt_q));
    // A grant held across an enabled edge must belong to a master requesting at that edge.
    a_gnt_on_req: assert property (@(posedge clk) disable iff (rst)
        (!$past(rst) && $past(en)) |-> ((gnt_q & ~$past(req)) == '0));

endmodule

// File: tb/tb_arb_rr_sched.sv
// Bench for arb_rr_sched: directed scenarios plus random traffic checked against
// an owner/last/held-count reference model, on MAX_HOLD=4 and MAX_HOLD=0 instances.
module tb_arb_rr_sched;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] req, lock;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b, pre_a, pre_b;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: index 0 models MAX_HOLD=4, index 1 models MAX_HOLD=0.
  int   m_owner[2];
  int   m_last[2];
  int   m_held[2];
  logic m_pre[2];
  int   m_mh[2];

  always #5 clk = ~clk;

  arb_rr_sched #(.N(4), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .en(en),
    .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a), .preempt(pre_a)
  );

  arb_rr_sched #(.N(4), .MAX_HOLD(0)) u_dut_nohold (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .en(en),
    .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b), .preempt(pre_b)
  );

  function automatic int pick(input logic [3:0] v, input int from);
    for (int i = 1; i <= 4; i++) begin
      int j;
      j = (from + i) % 4;
      if (((v >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt(input int i);
    return (m_owner[i] < 0) ? 4'b0000 : 4'(1 << m_owner[i]);
  endfunction

  function automatic void model_step(input int i);
    logic [3:0] others;
    int w;
    if (rst) begin
      m_owner[i] = -1; m_last[i] = 3; m_held[i] = 0; m_pre[i] = 1'b0;
      return;
    end
    m_pre[i] = 1'b0;
    if (!en) return;
    if (m_owner[i] < 0) begin
      w = pick(req, m_last[i]);
      if (w >= 0) begin m_owner[i] = w; m_last[i] = w; m_held[i] = 0; end
    end else begin
      others = req & ~(4'(1 << m_owner[i]));
      if (((req >> m_owner[i]) & 4'd1) == 4'd0) begin
        if (others != 4'd0) begin
          w = pick(others, m_owner[i]);
          m_owner[i] = w; m_last[i] = w; m_held[i] = 0;
        end else begin
          m_owner[i] = -1;
        end
      end else if (m_mh[i] != 0 && m_held[i] >= m_mh[i] - 1 &&
                   ((lock >> m_owner[i]) & 4'd1) == 4'd0 && others != 4'd0) begin
        w = pick(others, m_owner[i]);
        m_owner[i] = w; m_last[i] = w; m_held[i] = 0; m_pre[i] = 1'b1;
      end else begin
        m_held[i]++;
      end
    end
  endfunction

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 4'b0; lock = 4'b0;
    tick(); tick();
    rst = 1'b0;
    tests_run++; if (gnt_a !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0000", gnt_a); end
    tests_run++; if (id_a !== 2'd0) begin tests_failed++; $display("FAIL reset_gnt_id: got %0d want 0", id_a); end
    tests_run++; if (busy_a !== 1'b0 || pre_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_pre: got %b%b want 00", busy_a, pre_a); end
    tests_run++; if (gnt_b !== 4'b0000 || busy_b !== 1'b0) begin tests_failed++; $display("FAIL reset_nohold: got %b/%b want 0000/0", gnt_b, busy_b); end
  endtask

  task automatic test_handover();
    do_reset();
    req = 4'b1010;
    tick();
    tests_run++; if (gnt_a !== 4'b0010 || id_a !== 2'd1) begin tests_failed++; $display("FAIL first_grant: got %b id %0d want 0010 id 1", gnt_a, id_a); end
    tick(); tick();
    tests_run++; if (gnt_a !== 4'b0010) begin tests_failed++; $display("FAIL hold_m1: got %b want 0010", gnt_a); end
    req = 4'b1000;
    tick();
    tests_run++; if (gnt_a !== 4'b1000 || id_a !== 2'd3 || busy_a !== 1'b1) begin tests_failed++; $display("FAIL handover: got %b id %0d busy %b want 1000 id 3 busy 1", gnt_a, id_a, busy_a); end
    tests_run++; if (pre_a !== 1'b0) begin tests_failed++; $display("FAIL handover_pre: got %b want 0", pre_a); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_rotation();
    int cur, nxt;
    do_reset();
    req = 4'b1111; lock = 4'b0;
    tick();
    tests_run++; if (gnt_a !== 4'b0001) begin tests_failed++; $display("FAIL rot_start: got %b want 0001", gnt_a); end
    cur = 0;
    for (int s = 0; s < 4; s++) begin
      nxt = (cur + 1) % 4;
      for (int c = 0; c < 3; c++) begin
        tick();
        tests_run++; if (gnt_a !== 4'(1 << cur) || pre_a !== 1'b0) begin tests_failed++; $display("FAIL rot_hold: got %b pre %b want %b pre 0", gnt_a, pre_a, 4'(1 << cur)); end
      end
      tick();
      tests_run++; if (gnt_a !== 4'(1 << nxt) || pre_a !== 1'b1 || id_a !== 2'(nxt)) begin tests_failed++; $display("FAIL rot_change: got %b pre %b id %0d want %b pre 1 id %0d", gnt_a, pre_a, id_a, 4'(1 << nxt), nxt); end
      cur = nxt;
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_lock();
    do_reset();
    req = 4'b0011; lock = 4'b0001;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      tests_run++; if (gnt_a !== 4'b0001 || pre_a !== 1'b0) begin tests_failed++; $display("FAIL lock_hold: got %b pre %b want 0001 pre 0", gnt_a, pre_a); end
    end
    lock = 4'b0000;
    tick();
    tests_run++; if (gnt_a !== 4'b0010 || pre_a !== 1'b1) begin tests_failed++; $display("FAIL lock_release: got %b pre %b want 0010 pre 1", gnt_a, pre_a); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests_run++; if (gnt_a !== 4'b0100 || pre_a !== 1'b0 || busy_a !== 1'b1) begin tests_failed++; $display("FAIL single_hold: got %b pre %b busy %b want 0100 0 1", gnt_a, pre_a, busy_a); end
    end
    req = 4'b0000;
    tick();
    tests_run++; if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin tests_failed++; $display("FAIL single_release: got %b busy %b want 0000 0", gnt_a, busy_a); end
  endtask

  task automatic test_enable_reset();
    do_reset();
    en = 1'b0; req = 4'b0001;
    tick(); tick(); tick();
    tests_run++; if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin tests_failed++; $display("FAIL en_off: got %b busy %b want 0000 0", gnt_a, busy_a); end
    en = 1'b1;
    tick();
    tests_run++; if (gnt_a !== 4'b0001) begin tests_failed++; $display("FAIL en_on: got %b want 0001", gnt_a); end
    req = 4'b1001;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin tests_failed++; $display("FAIL mid_reset: got %b busy %b want 0000 0", gnt_a, busy_a); end
    tick();
    tests_run++; if (gnt_a !== 4'b0001 || id_a !== 2'd0) begin tests_failed++; $display("FAIL post_reset_prio: got %b id %0d want 0001 id 0", gnt_a, id_a); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_no_hold();
    do_reset();
    req = 4'b0011;
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      tests_run++; if (gnt_b !== 4'b0001 || pre_b !== 1'b0) begin tests_failed++; $display("FAIL nohold_keep: got %b pre %b want 0001 pre 0", gnt_b, pre_b); end
    end
    req = 4'b0010;
    tick();
    tests_run++; if (gnt_b !== 4'b0010 || id_b !== 2'd1 || pre_b !== 1'b0) begin tests_failed++; $display("FAIL nohold_handover: got %b id %0d pre %b want 0010 id 1 pre 0", gnt_b, id_b, pre_b); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) lock = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
      tests_run++; if (gnt_a !== exp_gnt(0) || busy_a !== (m_owner[0] >= 0) || pre_a !== m_pre[0]) begin tests_failed++; $display("FAIL rand_a: cyc %0d got gnt %b busy %b pre %b want %b %b %b", c, gnt_a, busy_a, pre_a, exp_gnt(0), m_owner[0] >= 0, m_pre[0]); end
      tests_run++; if (gnt_b !== exp_gnt(1) || busy_b !== (m_owner[1] >= 0) || pre_b !== m_pre[1]) begin tests_failed++; $display("FAIL rand_b: cyc %0d got gnt %b busy %b pre %b want %b %b %b", c, gnt_b, busy_b, pre_b, exp_gnt(1), m_owner[1] >= 0, m_pre[1]); end
      if (m_owner[0] >= 0) begin
        tests_run++; if (id_a !== 2'(m_owner[0])) begin tests_failed++; $display("FAIL rand_id_a: cyc %0d got %0d want %0d", c, id_a, m_owner[0]); end
      end
      if (m_owner[1] >= 0) begin
        tests_run++; if (id_b !== 2'(m_owner[1])) begin tests_failed++; $display("FAIL rand_id_b: cyc %0d got %0d want %0d", c, id_b, m_owner[1]); end
      end
    end
    rst = 1'b0; en = 1'b1; req = 4'b0; lock = 4'b0;
    tick();
  endtask

  initial begin
    m_mh[0] = 4;
    m_mh[1] = 0;
    rst = 1'b1; en = 1'b1; req = 4'b0; lock = 4'b0;
    test_reset();
    test_handover();
    test_rotation();
    test_lock();
    test_single();
    test_enable_reset();
    test_no_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
